fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that drives the 64-word instruction ROM's word address and owns the fetch PC.
- Buffers fetched words in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles branch redirects (flush plus new PC) and detects out-of-range or misaligned PCs.
- Sits between the instruction ROM (combinational read, same-cycle data) and the pipeline's IF/ID register.

Parameters:
- PW, 64, PC width in bits.
- IW, 32, instruction width in bits.
- AW, 6, ROM word-address width (ROM holds 2**AW words).
- DEPTH, 2, prefetch FIFO entries (power of two, at least 2).
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin fetching from the current PC.
- imem_addr  out  AW  ROM word address; always equals pc[AW+1:2].
- imem_q  in  IW  ROM read data for imem_addr, valid in the same cycle.
- redirect_valid  in  1  branch taken or redirect request.
- redirect_pc  in  PW  new fetch PC.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  IW  instruction at the FIFO head.
- out_pc  out  PW  PC of the FIFO head.
- busy  out  1  state is RUN.
- fault  out  1  sticky fetch fault; state is FAULT.
- halted  out  1  state is HALT (optional feature only).

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; pc = RESET_PC; FIFO empty.
  - out_valid, busy, fault and halted all 0; out_instr and out_pc 0; imem_addr = RESET_PC[AW+1:2].
  - Reset asserted mid-operation discards all FIFO contents immediately.
- States:
  - IDLE: no fetch. start moves to RUN. Redirect in IDLE is ignored.
  - RUN: fetch as described below.
  - FAULT: no fetch; fault = 1; FIFO contents still drain to decode.
  - HALT: exists only with the optional feature.
- PC legality: a PC is legal iff pc[1:0] == 0 and pc[PW-1:AW+2] == 0.
- Push (RUN only): on an edge where there is no redirect, pc is legal, and the FIFO is not full (or a pop occurs the same edge):
  - Write {pc, imem_q} at the FIFO tail.
  - pc <= pc + 4.
- Sequential increment into an illegal PC (past the last word):
  - The last word is pushed normally.
  - The next edge enters FAULT with no push.
- Pop: an edge with out_valid && out_ready removes the head. Simultaneous push and pop at full is allowed, and count is unchanged.
- out_valid = (count != 0). out_instr and out_pc come from the head register and are stable while out_valid && !out_ready.
- Latency:
  - start sampled at edge k, then push at edge k+1, then out_valid = 1 after edge k+1.
  - Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Redirect (RUN, FAULT or HALT), highest priority:
  - Flush the FIFO (count = 0, so out_valid = 0 next cycle).
  - No push and no pop is counted that edge.
  - pc <= redirect_pc.
  - Next state is RUN if redirect_pc is legal, otherwise FAULT.
  - A redirect while FAULT is active clears fault if the target is legal.
- start while RUN, FAULT or HALT is ignored.
- pc arithmetic is modulo 2**PW. A wrap to an illegal address is caught by the legality rule above.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - When a pushed word equals 32'hB400001F (CBZ XZR, #0 self-loop), the word is pushed and the state moves to HALT.
  - HALT: no further pushes, halted = 1, busy = 0, FIFO drains normally.
  - A redirect leaves HALT under the normal redirect rules.
- Not defined: no HALT state, halted is tied 0, and the self-loop word is fetched repeatedly like any other word.

Test Plan:
- Sequential fetch: bench ROM with word i = 32'h1000_0000 + i; reset, start, out_ready = 1 → out_pc 0,4,8,12 on consecutive cycles with out_instr 10000000..10000003; first out_valid exactly one cycle after start.
- Backpressure: out_ready = 0 for 5 cycles after start → count saturates at 2, imem_addr holds at 2, out_pc holds at 0. Release → 0,4,8,12 in order, no loss, no duplicates.
- Redirect flush: FIFO holds PCs 0x8 and 0xC, redirect to 0x40 → next valid out_pc = 0x40 with instr 10000010; 0x8 and 0xC are never accepted.
- Misaligned redirect: redirect_pc = 0x42 → fault = 1, busy = 0, out_valid = 0 next cycle. Then redirect_pc = 0x10 → fault = 0, out_pc 0x10 follows.
- Run-off end: redirect to 0xF8 → words at 0xF8 and 0xFC delivered, then fault = 1 and no entry with out_pc 0x100 ever appears. Separately, assert reset_n low mid-RUN → out_valid and busy drop before the next clock edge.
- FETCH_HALT_DETECT_EN: word 5 = 32'hB400001F → out_pc 0x14 delivered, halted = 1, no out_pc 0x18. Redirect to 0 → halted = 0, fetch resumes from 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: ROM address/data pair plus the decode-side
// valid/ready bundle carrying the fetched instruction and its PC.
interface fetch_sequencer_if #(
    parameter int PW = 64,
    parameter int IW = 32,
    parameter int AW = 6
);
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_q;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_q,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_q,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC owner, ROM addressing and prefetch FIFO.
// Define FETCH_HALT_DETECT_EN to stop fetching on a CBZ XZR,#0 self-loop.
module fetch_sequencer #(
    parameter int              PW       = 64,
    parameter int              IW       = 32,
    parameter int              AW       = 6,
    parameter int              DEPTH    = 2,
    parameter logic [PW-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [PW-1:0]     redirect_pc,
    fetch_sequencer_if.master bus,
    output logic              busy,
    output logic              fault,
    output logic              halted
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic [IW-1:0] HALT_WORD = IW'(32'hB400001F);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_e;
`endif

    function automatic logic pc_legal(input logic [PW-1:0] a);
        return (a[1:0] == 2'b00) && (a[PW-1:AW+2] == '0);
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [PTRW-1:0] rd_q, rd_d;
    logic [PTRW-1:0] wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   fpc_q [DEPTH];
    logic [PW-1:0]   fpc_d [DEPTH];
    logic [IW-1:0]   fin_q [DEPTH];
    logic [IW-1:0]   fin_d [DEPTH];

    logic redir;
    logic pc_ok;
    logic full;
    logic pop;
    logic push;

    // Redirect outranks everything; IDLE ignores it.
    assign redir = redirect_valid && (state_q != S_IDLE);
    assign pc_ok = pc_legal(pc_q);
    assign full  = (cnt_q == CW'(DEPTH));
    assign pop   = bus.out_valid && bus.out_ready && !redir;
    assign push  = (state_q == S_RUN) && !redir && pc_ok && (!full || pop);

    assign bus.imem_addr = pc_q[AW+1:2];
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_instr = fin_q[rd_q];
    assign bus.out_pc    = fpc_q[rd_q];
    assign busy          = (state_q == S_RUN);
    assign fault         = (state_q == S_FAULT);
`ifdef FETCH_HALT_DETECT_EN
    assign halted        = (state_q == S_HALT);
`else
    assign halted        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        fpc_d   = fpc_q;
        fin_d   = fin_q;
        if (redir) begin
            cnt_d   = '0;
            wr_d    = rd_q;
            pc_d    = redirect_pc;
            state_d = pc_legal(redirect_pc) ? S_RUN : S_FAULT;
        end else begin
            if (push) begin
                fpc_d[wr_q] = pc_q;
                fin_d[wr_q] = bus.imem_q;
                wr_d        = wr_q + PTRW'(1);
                pc_d        = pc_q + PW'(4);
            end
            if (pop) begin
                rd_d = rd_q + PTRW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    // Sequential walk past the last ROM word faults here.
                    if (!pc_ok) begin
                        state_d = S_FAULT;
                    end
`ifdef FETCH_HALT_DETECT_EN
                    else if (push && (bus.imem_q == HALT_WORD)) begin
                        state_d = S_HALT;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fpc_q[i] <= '0;
                fin_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            fpc_q   <= fpc_d;
            fin_q   <= fin_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed fetch, backpressure, redirect, fault
// and (with FETCH_HALT_DETECT_EN) self-loop halt scenarios.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;
    logic        fault;
    logic        halted;
    logic [31:0] rom [0:63];

    int n_cmp;
    int n_bad;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .busy           (busy),
        .fault          (fault),
        .halted         (halted)
    );

    assign bus.imem_q = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc,
                            input logic [31:0] ins);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_instr"}, 64'(bus.out_instr), 64'(ins));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset_n        = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
`ifdef FETCH_HALT_DETECT_EN
        rom[5] = 32'hB400_001F;
`endif

        // Reset state
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_pc", bus.out_pc, 64'd0);
        chk("rst_instr", 64'(bus.out_instr), 64'd0);
        tick();
        reset_n = 1'b1;

        // Sequential fetch, first valid exactly one edge after start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq_busy", 64'(busy), 64'd1);
        chk("seq_early_valid", 64'(bus.out_valid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_head("seq", 64'(4 * i), 32'h1000_0000 + 32'(i));
            tick();
        end

        // Reset mid-RUN drops valid and busy before the next edge
        reset_n = 1'b0;
        #2;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Backpressure: FIFO fills to two, pc stalls at word 2
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_head("bp_hold", 64'd0, 32'h1000_0000);
        chk("bp_addr", 64'(bus.imem_addr), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_head("bp_rel", 64'(4 * i), 32'h1000_0000 + 32'(i));
            tick();
        end

        // Redirect flush with 0x8 and 0xC queued
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        chk_head("fl_pre", 64'h8, 32'h1000_0002);
        chk("fl_addr", 64'(bus.imem_addr), 64'd4);
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();
        redirect_valid = 1'b0;
        chk("fl_flushed", 64'(bus.out_valid), 64'd0);
        tick();
        chk_head("fl_new", 64'h40, 32'h1000_0010);

        // Misaligned redirect faults, legal redirect recovers
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        tick();
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_busy", 64'(busy), 64'd0);
        chk("mis_valid", 64'(bus.out_valid), 64'd0);
        redirect_pc = 64'h10;
        tick();
        redirect_valid = 1'b0;
        chk("rec_fault", 64'(fault), 64'd0);
        chk("rec_busy", 64'(busy), 64'd1);
        tick();
        chk_head("rec", 64'h10, 32'h1000_0004);

        // Run off the end of the ROM
        redirect_valid = 1'b1;
        redirect_pc    = 64'hF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk_head("end_f8", 64'hF8, 32'h1000_003E);
        tick();
        chk_head("end_fc", 64'hFC, 32'h1000_003F);
        tick();
        chk("end_fault", 64'(fault), 64'd1);
        chk("end_valid", 64'(bus.out_valid), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("end_start_ign", 64'(fault), 64'd1);
        chk("end_no_100", 64'(bus.out_valid), 64'd0);

`ifdef FETCH_HALT_DETECT_EN
        // Self-loop word at 0x14 halts fetch after being delivered
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_head("h_seq", 64'(4 * i), 32'h1000_0000 + 32'(i));
            tick();
        end
        chk_head("h_loop", 64'h14, 32'hB400_001F);
        chk("h_halted", 64'(halted), 64'd1);
        tick();
        tick();
        chk("h_no_18", 64'(bus.out_valid), 64'd0);
        chk("h_busy", 64'(busy), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        chk("h_resume", 64'(halted), 64'd0);
        tick();
        chk_head("h_again", 64'h0, 32'h1000_0000);
`else
        chk("no_halt", 64'(halted), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
